// File: rtl/scaled_window_gen.sv
// scaled_window_gen
// Timing and addressing core for the upscaled GBA window. It turns the HDMI
// raster counters into a window-active flag, source pixel/line indices and
// sub-pixel phases. It also runs the line-cache request handshake and the
// HDMI frame-alignment (setStart) sequence.
// X and Y scale factors are independent and are picked up at frame end or
// when alignment starts. Every output is registered one cycle after cx/cy.
//
// Handshake: nextLineReq is a level request that stays high until a cycle
// in which nextLineAck is sampled high. An ack in the same cycle as a new
// request point wins, so the request clears. An ack while nothing is pending
// has no effect. A request point reached while a request is still pending
// sets lineOverrun, which stays set until rst; the pending request stays a
// single request.
module scaled_window_gen #(
    parameter int FRAME_W   = 1280,
    parameter int FRAME_H   = 720,
    parameter int SRC_W     = 240,
    parameter int SRC_H     = 160,
    parameter int MAX_SCALE = 6,
    parameter int REQ_LEAD  = 8
) (
    input  logic        pxlClk,
    input  logic        rst,
    input  logic [11:0] cx,
    input  logic [10:0] cy,
    input  logic [2:0]  scaleX,
    input  logic [2:0]  scaleY,
    input  logic        newFrameIn,
    input  logic        sameLine,
    input  logic        nextLineAck,
    output logic        drawActive,
    output logic [7:0]  pxlIdx,
    output logic [7:0]  lineIdx,
    output logic [2:0]  subX,
    output logic [2:0]  subY,
    output logic        nextLineReq,
    output logic        cacheUpdate,
    output logic        setStart,
    output logic [11:0] setStartX,
    output logic [10:0] setStartY,
    output logic        locked,
    output logic        lineOverrun,
    output logic [1:0]  syncState
);

    // Sync FSM encoding
    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_ALIGN    = 2'd1;
    localparam logic [1:0] ST_LOCKED   = 2'd2;

    // Geometry constants at a common 13-bit width (wide enough for 6*240)
    localparam logic [12:0] FW       = 13'(FRAME_W);
    localparam logic [12:0] FH       = 13'(FRAME_H);
    localparam logic [12:0] SW       = 13'(SRC_W);
    localparam logic [12:0] SH       = 13'(SRC_H);
    localparam logic [12:0] MS       = 13'(MAX_SCALE);
    localparam logic [12:0] LAST_X   = 13'(FRAME_W - 1);
    localparam logic [12:0] LAST_Y   = 13'(FRAME_H - 1);
    localparam logic [12:0] REQ_X    = 13'(FRAME_W - REQ_LEAD);
    localparam logic [12:0] RST_XS   = 13'((FRAME_W - SRC_W) / 2);
    localparam logic [12:0] RST_XE   = 13'((FRAME_W - SRC_W) / 2 + SRC_W);
    localparam logic [12:0] RST_YS   = 13'((FRAME_H - SRC_H) / 2);
    localparam logic [12:0] RST_YE   = 13'((FRAME_H - SRC_H) / 2 + SRC_H);
    localparam logic [7:0]  PXL_MAX  = 8'(SRC_W - 1);
    localparam logic [7:0]  LINE_MAX = 8'(SRC_H - 1);

    // Active scale and window bounds (end bounds are exclusive)
    logic [2:0]  s_x, s_y;
    logic [12:0] x_start, x_end, y_start, y_end;
    logic [2:0]  s_x_n, s_y_n;
    logic [12:0] x_start_n, x_end_n, y_start_n, y_end_n;

    // Sync FSM and edge-detect history
    logic [1:0]  state, state_n;
    logic        nf_q;
    logic [10:0] cy_q;

    logic [12:0] cx_w, cy_w;
    logic [12:0] span_x, span_y;
    logic        x_ok, y_ok;
    logic        nf_rise, frame_end, latch;
    logic        in_x, in_y, in_win;
    logic        req_set;
    logic [12:0] set_y_full;

    assign cx_w = {1'b0, cx};
    assign cy_w = {2'b00, cy};

    assign span_x = {10'b0, scaleX} * SW;
    assign span_y = {10'b0, scaleY} * SH;

    // A requested scale is usable only if it is nonzero, within range,
    // and the scaled image fits in the frame.
    assign x_ok = (scaleX != 3'd0) && ({10'b0, scaleX} <= MS) && (span_x <= FW);
    assign y_ok = (scaleY != 3'd0) && ({10'b0, scaleY} <= MS) && (span_y <= FH);

    assign nf_rise   = newFrameIn & ~nf_q;
    assign frame_end = (cx_w == LAST_X) && (cy_w == LAST_Y);
    assign latch     = frame_end || nf_rise;

    assign in_x   = (cx_w >= x_start) && (cx_w < x_end);
    assign in_y   = (cy_w >= y_start) && (cy_w < y_end);
    assign in_win = in_x && in_y;

    assign req_set = (cx_w == REQ_X) && (state == ST_LOCKED) && !sameLine &&
                     (cy_w >= y_start) && (subY == s_y - 3'd1);

    assign syncState = state;

    // Candidate scale/window values; illegal requests leave an axis unchanged
    always_comb begin
        s_x_n     = s_x;
        x_start_n = x_start;
        x_end_n   = x_end;
        s_y_n     = s_y;
        y_start_n = y_start;
        y_end_n   = y_end;
        if (latch) begin
            if (x_ok) begin
                s_x_n     = scaleX;
                x_start_n = (FW - span_x) >> 1;
                x_end_n   = ((FW - span_x) >> 1) + span_x;
            end
            if (y_ok) begin
                s_y_n     = scaleY;
                y_start_n = (FH - span_y) >> 1;
                y_end_n   = ((FH - span_y) >> 1) + span_y;
            end
        end
    end

    // Next sync state: a newFrameIn edge always (re)starts alignment
    always_comb begin
        state_n = state;
        if (nf_rise) begin
            state_n = ST_ALIGN;
        end else if ((state == ST_ALIGN) && (cy != cy_q)) begin
            state_n = ST_LOCKED;
        end
    end

    assign set_y_full = y_start_n - 13'd2;

    // Scale/window registers, FSM state and edge-detect history
    always_ff @(posedge pxlClk) begin
        if (rst) begin
            s_x     <= 3'd1;
            s_y     <= 3'd1;
            x_start <= RST_XS;
            x_end   <= RST_XE;
            y_start <= RST_YS;
            y_end   <= RST_YE;
            state   <= ST_UNLOCKED;
            nf_q    <= 1'b0;
            cy_q    <= 11'd0;
        end else begin
            s_x     <= s_x_n;
            s_y     <= s_y_n;
            x_start <= x_start_n;
            x_end   <= x_end_n;
            y_start <= y_start_n;
            y_end   <= y_end_n;
            state   <= state_n;
            nf_q    <= newFrameIn;
            cy_q    <= cy;
        end
    end

    // Alignment outputs: preload the HDMI counters while aligning
    always_ff @(posedge pxlClk) begin
        if (rst) begin
            setStart  <= 1'b0;
            setStartX <= 12'd0;
            setStartY <= 11'd0;
            locked    <= 1'b0;
        end else begin
            setStart  <= (state_n == ST_ALIGN);
            setStartX <= 12'd0;
            setStartY <= (state_n == ST_ALIGN) ? set_y_full[10:0] : 11'd0;
            locked    <= (state_n == ST_LOCKED);
        end
    end

    // Window flag and horizontal phase/index; the first window pixel starts at zero
    always_ff @(posedge pxlClk) begin
        if (rst) begin
            drawActive <= 1'b0;
            subX       <= 3'd0;
            pxlIdx     <= 8'd0;
        end else begin
            drawActive <= in_win;
            if (in_win && drawActive) begin
                if (subX >= s_x - 3'd1) begin
                    subX <= 3'd0;
                    if (pxlIdx != PXL_MAX) begin
                        pxlIdx <= pxlIdx + 8'd1;
                    end
                end else begin
                    subX <= subX + 3'd1;
                end
            end else begin
                subX   <= 3'd0;
                pxlIdx <= 8'd0;
            end
        end
    end

    // Vertical phase/index, advanced once per line at the last pixel
    always_ff @(posedge pxlClk) begin
        if (rst) begin
            subY    <= 3'd0;
            lineIdx <= 8'd0;
        end else if (cx_w == LAST_X) begin
            if ((cy_w == LAST_Y) || (state == ST_ALIGN)) begin
                subY    <= 3'd0;
                lineIdx <= 8'd0;
            end else if (in_y) begin
                if (subY >= s_y - 3'd1) begin
                    subY <= 3'd0;
                    if (lineIdx != LINE_MAX) begin
                        lineIdx <= lineIdx + 8'd1;
                    end
                end else begin
                    subY <= subY + 3'd1;
                end
            end
        end
    end

    // Cache update strobe at the request point of every line
    always_ff @(posedge pxlClk) begin
        if (rst) begin
            cacheUpdate <= 1'b0;
        end else begin
            cacheUpdate <= (cx_w == REQ_X);
        end
    end

    // Line request handshake with sticky overrun detection; ack has priority
    always_ff @(posedge pxlClk) begin
        if (rst) begin
            nextLineReq <= 1'b0;
            lineOverrun <= 1'b0;
        end else if (nextLineAck) begin
            nextLineReq <= 1'b0;
        end else if (req_set) begin
            if (nextLineReq) begin
                lineOverrun <= 1'b1;
            end
            nextLineReq <= 1'b1;
        end
    end

endmodule

// File: tb/tb_scaled_window_gen.sv
// Directed bench for scaled_window_gen: geometry, counters, alignment,
// line-request handshake and mid-frame reset.
module tb_scaled_window_gen;

    logic        pxlClk;
    logic        rst;
    logic [11:0] cx;
    logic [10:0] cy;
    logic [2:0]  scaleX, scaleY;
    logic        newFrameIn, sameLine, nextLineAck;
    logic        drawActive;
    logic [7:0]  pxlIdx, lineIdx;
    logic [2:0]  subX, subY;
    logic        nextLineReq, cacheUpdate, setStart;
    logic [11:0] setStartX;
    logic [10:0] setStartY;
    logic        locked, lineOverrun;
    logic [1:0]  syncState;

    int checks = 0;
    int errors = 0;

    scaled_window_gen dut (
        .pxlClk      (pxlClk),
        .rst         (rst),
        .cx          (cx),
        .cy          (cy),
        .scaleX      (scaleX),
        .scaleY      (scaleY),
        .newFrameIn  (newFrameIn),
        .sameLine    (sameLine),
        .nextLineAck (nextLineAck),
        .drawActive  (drawActive),
        .pxlIdx      (pxlIdx),
        .lineIdx     (lineIdx),
        .subX        (subX),
        .subY        (subY),
        .nextLineReq (nextLineReq),
        .cacheUpdate (cacheUpdate),
        .setStart    (setStart),
        .setStartX   (setStartX),
        .setStartY   (setStartY),
        .locked      (locked),
        .lineOverrun (lineOverrun),
        .syncState   (syncState)
    );

    // Clock
    initial pxlClk = 1'b0;
    always #5 pxlClk = ~pxlClk;

    // Apply one raster position, clock it in, sample just after the edge
    task automatic step(input logic [11:0] x, input logic [10:0] y);
        cx = x;
        cy = y;
        @(posedge pxlClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_l;
        rst = 1'b1; cx = 12'd0; cy = 11'd0;
        scaleX = 3'd3; scaleY = 3'd3;
        newFrameIn = 1'b0; sameLine = 1'b0; nextLineAck = 1'b0;

        // Reset state
        step(12'd0, 11'd0);
        step(12'd0, 11'd0);
        chk("rst_draw", drawActive, 0);
        chk("rst_pxl", pxlIdx, 0);
        chk("rst_line", lineIdx, 0);
        chk("rst_subx", subX, 0);
        chk("rst_suby", subY, 0);
        chk("rst_req", nextLineReq, 0);
        chk("rst_cupd", cacheUpdate, 0);
        chk("rst_setstart", setStart, 0);
        chk("rst_setx", setStartX, 0);
        chk("rst_sety", setStartY, 0);
        chk("rst_locked", locked, 0);
        chk("rst_ovr", lineOverrun, 0);
        chk("rst_state", syncState, 0);
        rst = 1'b0;

        // Scale 3/3 latched at frame end -> window x 280..999, y 120..599
        step(12'd1279, 11'd719);
        step(12'd279, 11'd120);
        chk("x_before", drawActive, 0);
        step(12'd280, 11'd120);
        chk("x_first", drawActive, 1);
        chk("pxl_first", pxlIdx, 0);
        chk("subx_first", subX, 0);
        for (int x = 281; x <= 999; x++) begin
            step(12'(x), 11'd120);
            chk("pxl_run", pxlIdx, (x - 280) / 3);
            chk("subx_run", subX, (x - 280) % 3);
        end
        chk("pxl_last", pxlIdx, 239);
        step(12'd1000, 11'd120);
        chk("x_after", drawActive, 0);
        chk("pxl_after", pxlIdx, 0);
        step(12'd280, 11'd119);
        chk("y_before", drawActive, 0);
        step(12'd999, 11'd599);
        chk("last_pix", drawActive, 1);
        step(12'd999, 11'd600);
        chk("y_after", drawActive, 0);
        step(12'd1272, 11'd100);
        chk("cupd_on", cacheUpdate, 1);
        step(12'd1273, 11'd100);
        chk("cupd_off", cacheUpdate, 0);

        // Vertical counters across the whole window at scale 3
        for (int y = 120; y <= 599; y++) begin
            step(12'd1279, 11'(y));
            exp_l = (y - 119) / 3;
            if (exp_l > 159) exp_l = 159;
            chk("line_run", lineIdx, exp_l);
            chk("suby_run", subY, (y - 119) % 3);
        end
        step(12'd1279, 11'd719);
        chk("line_fend", lineIdx, 0);
        chk("suby_fend", subY, 0);

        // scaleX=6 is ignored mid-frame and rejected at frame end
        scaleX = 3'd6;
        step(12'd280, 11'd120);
        chk("sx6_mid", drawActive, 1);
        step(12'd1279, 11'd719);
        step(12'd279, 11'd120);
        chk("sx6_lo", drawActive, 0);
        step(12'd280, 11'd120);
        chk("sx6_in", drawActive, 1);
        step(12'd1000, 11'd120);
        chk("sx6_hi", drawActive, 0);
        scaleX = 3'd3;

        // scaleY=4 latched on ALIGN entry -> yStart=40, setStartY=38
        scaleY = 3'd4;
        newFrameIn = 1'b1;
        step(12'd10, 11'd50);
        chk("al_setstart", setStart, 1);
        chk("al_sety", setStartY, 38);
        chk("al_setx", setStartX, 0);
        chk("al_locked", locked, 0);
        step(12'd11, 11'd50);
        chk("al_hold", setStart, 1);
        step(12'd12, 11'd51);
        chk("lk_setstart", setStart, 0);
        chk("lk_locked", locked, 1);
        step(12'd280, 11'd39);
        chk("y4_lo", drawActive, 0);
        step(12'd280, 11'd40);
        chk("y4_in", drawActive, 1);
        step(12'd280, 11'd679);
        chk("y4_last", drawActive, 1);
        step(12'd280, 11'd680);
        chk("y4_hi", drawActive, 0);

        // Scale 2/2 while locked -> x 400..879, y 200..519
        scaleX = 3'd2; scaleY = 3'd2;
        step(12'd1279, 11'd719);
        step(12'd1272, 11'd200);
        chk("req_l200", nextLineReq, 0);
        step(12'd1279, 11'd200);
        chk("suby_200", subY, 1);
        step(12'd1272, 11'd201);
        chk("req_l201", nextLineReq, 1);
        for (int x = 1273; x <= 1276; x++) begin
            step(12'(x), 11'd201);
            chk("req_hold", nextLineReq, 1);
        end
        nextLineAck = 1'b1;
        step(12'd1277, 11'd201);
        chk("req_ack", nextLineReq, 0);
        nextLineAck = 1'b0;
        step(12'd1279, 11'd201);
        chk("line_201", lineIdx, 1);
        chk("suby_201", subY, 0);
        step(12'd1272, 11'd202);
        chk("req_l202", nextLineReq, 0);
        step(12'd1279, 11'd202);
        step(12'd1272, 11'd203);
        chk("req_l203", nextLineReq, 1);
        nextLineAck = 1'b1;
        step(12'd1273, 11'd203);
        chk("req_ack2", nextLineReq, 0);
        nextLineAck = 1'b0;
        step(12'd1279, 11'd203);
        step(12'd1279, 11'd204);
        chk("line_204", lineIdx, 2);
        chk("suby_204", subY, 1);
        nextLineAck = 1'b1;
        step(12'd1272, 11'd205);
        chk("req_ackwins", nextLineReq, 0);
        chk("ovr_ackwins", lineOverrun, 0);
        nextLineAck = 1'b0;
        sameLine = 1'b1;
        step(12'd1272, 11'd205);
        chk("req_sameline", nextLineReq, 0);
        sameLine = 1'b0;

        // Two request points without ack -> sticky overrun
        step(12'd1272, 11'd205);
        chk("ovr_req1", nextLineReq, 1);
        step(12'd1273, 11'd205);
        chk("ovr_pre", lineOverrun, 0);
        step(12'd1272, 11'd205);
        chk("ovr_set", lineOverrun, 1);
        chk("ovr_req2", nextLineReq, 1);
        step(12'd100, 11'd205);
        chk("ovr_sticky", lineOverrun, 1);
        nextLineAck = 1'b1;
        step(12'd101, 11'd205);
        chk("ovr_ack", nextLineReq, 0);
        chk("ovr_keep", lineOverrun, 1);
        step(12'd102, 11'd205);
        chk("ack_idle", nextLineReq, 0);
        nextLineAck = 1'b0;

        // Scale-2 horizontal phase, then reset at cx=500, cy=300
        step(12'd497, 11'd300);
        chk("sx2_pxl0", pxlIdx, 0);
        step(12'd498, 11'd300);
        chk("sx2_sub1", subX, 1);
        step(12'd499, 11'd300);
        chk("sx2_pxl1", pxlIdx, 1);
        chk("sx2_sub0", subX, 0);
        rst = 1'b1;
        newFrameIn = 1'b0;
        step(12'd500, 11'd300);
        chk("mr_draw", drawActive, 0);
        chk("mr_pxl", pxlIdx, 0);
        chk("mr_locked", locked, 0);
        chk("mr_ovr", lineOverrun, 0);
        chk("mr_req", nextLineReq, 0);
        chk("mr_state", syncState, 0);
        rst = 1'b0;
        scaleX = 3'd1; scaleY = 3'd1;
        step(12'd1272, 11'd300);
        chk("mr_noreq", nextLineReq, 0);
        chk("mr_cupd", cacheUpdate, 1);
        newFrameIn = 1'b1;
        step(12'd10, 11'd300);
        chk("re_setstart", setStart, 1);
        chk("re_sety", setStartY, 278);
        step(12'd11, 11'd301);
        chk("re_locked", locked, 1);
        step(12'd1272, 11'd301);
        chk("re_req", nextLineReq, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
